hazard_stall_unit: RTL and testbench

//  Produces the per-stage stall/flush word (pStall_t) consumed by the pipeline control unit and pipeline latches.

---
 rtl/hazard_stall_unit_pkg.sv | 30 +++
 rtl/hazard_stall_unit_if.sv | 34 +++
 rtl/hazard_stall_unit_perf_counter.sv | 30 +++
 rtl/hazard_stall_unit.sv | 112 +++++++++++
 tb/tb_hazard_stall_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared register-index, stall-word and FSM state types
package cpu_types_pkg;
  localparam int REG_W_DEF = 5;
  typedef logic [REG_W_DEF-1:0] regbits_t;
endpackage

package pipeline_types_pkg;
  // Per-stage latch control word, pc_en is the MSB.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } pStall_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

  localparam pStall_t STALL_ALL_EN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
                                       idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};
  localparam pStall_t STALL_FROZEN = '{default: 1'b0};
  localparam pStall_t STALL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
                                       idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0};
endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - control-unit to hazard/stall unit signal bundle
interface hazard_stall_unit_if #(
  parameter int REG_W = cpu_types_pkg::REG_W_DEF
);
  import pipeline_types_pkg::*;

  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_dMemRead;
  logic [REG_W-1:0] ex_wsel;
  logic             ex_redirect;
  logic             mem_dMemRead;
  logic             mem_dMemWrite;
  logic             wb_halt;
  pStall_t          stall;
  logic             halted;

  // Control unit side: presents pipeline status, consumes the stall word.
  modport master (
    output ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dMemRead, ex_wsel,
           ex_redirect, mem_dMemRead, mem_dMemWrite, wb_halt,
    input  stall, halted
  );

  // Hazard unit side.
  modport slave (
    input  ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dMemRead, ex_wsel,
           ex_redirect, mem_dMemRead, mem_dMemWrite, wb_halt,
    output stall, halted
  );
endinterface

// File: rtl/hazard_stall_unit_perf_counter.sv
// rtl/hazard_stall_unit_perf_counter.sv - saturating event counter
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  // Advance on each event, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/flush word generator; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_stall_unit
  import cpu_types_pkg::*;
  import pipeline_types_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  hazard_stall_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);
  hz_state_t state_q, state_d;
  logic      redir_pend_q, redir_pend_d;
  pStall_t   stall;
  logic      halted;
  logic      data_wait;
  logic      load_use;
  logic      redirect;

  // A load in EX feeding the ID instruction; $zero is never a real dependency.
  always_comb begin
    load_use = hz.ex_dMemRead && (hz.ex_wsel != '0) &&
               ((hz.ex_wsel == hz.id_rs) || (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));
    data_wait = (hz.mem_dMemRead || hz.mem_dMemWrite) && !hz.dhit;
    redirect  = hz.ex_redirect || redir_pend_q;
  end

  // Prioritised stall word and next state: reset, halt, data wait, redirect, load-use, fetch wait.
  always_comb begin
    stall        = STALL_ALL_EN;
    halted       = 1'b0;
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    if (RST) begin
      stall   = STALL_RESET;
      state_d = RUN;
    end else if (state_q == HALTED) begin
      stall  = STALL_FROZEN;
      halted = 1'b1;
    end else begin
      if (data_wait) begin
        // Freeze everything; remember a redirect so it is applied once memory completes.
        stall   = STALL_FROZEN;
        state_d = MEM_WAIT;
        if (hz.ex_redirect) begin
          redir_pend_d = 1'b1;
        end
      end else begin
        state_d = RUN;
        if (redirect) begin
          // Younger instructions are squashed, so a coincident load-use needs no bubble.
          stall.ifid_flush = 1'b1;
          stall.idex_flush = 1'b1;
          redir_pend_d     = 1'b0;
        end else if (load_use || !hz.ihit) begin
          stall.pc_en      = 1'b0;
          stall.ifid_en    = 1'b0;
          stall.idex_flush = 1'b1;
        end
      end
      if (hz.wb_halt) begin
        state_d      = HALTED;
        redir_pend_d = 1'b0;
      end
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  assign hz.stall  = stall;
  assign hz.halted = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // Stalled-cycle and flush events, excluding reset and the halted state.
  always_comb begin
    stall_inc = !RST && (state_q != HALTED) && !stall.pc_en;
    flush_inc = !RST && stall.ifid_flush;
  end

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_count)
  );
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed vector bench for hazard_stall_unit
module tb_hazard_stall_unit;
  import pipeline_types_pkg::*;

  localparam logic [6:0] W_ALL_EN = 7'b1101011;
  localparam logic [6:0] W_BUBBLE = 7'b0001111;
  localparam logic [6:0] W_REDIR  = 7'b1111111;
  localparam logic [6:0] W_FROZEN = 7'b0000000;
  localparam logic [6:0] W_RESET  = 7'b0010100;

  typedef struct {
    string      nm;
    logic       ihit;
    logic       ex_rd;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       redir;
    logic       mem_rd;
    logic [6:0] exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  vec_t vecs[12];

  always #5 CLK = ~CLK;

  hazard_stall_unit_if #(.REG_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  hazard_stall_unit #(.REG_W(5), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  function automatic vec_t mk(string nm, logic ihit, logic ex_rd, logic [4:0] wsel, logic [4:0] rs,
                              logic [4:0] rt, logic uses_rt, logic redir, logic mem_rd, logic [6:0] exp);
    vec_t v;
    v.nm = nm; v.ihit = ihit; v.ex_rd = ex_rd; v.wsel = wsel; v.rs = rs; v.rt = rt;
    v.uses_rt = uses_rt; v.redir = redir; v.mem_rd = mem_rd; v.exp = exp;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_dMemRead = 1'b0; bus.ex_wsel = '0; bus.ex_redirect = 1'b0;
    bus.mem_dMemRead = 1'b0; bus.mem_dMemWrite = 1'b0; bus.wb_halt = 1'b0;
  endtask

  // Check the current cycle at the falling edge, track counter model, then move past the next rising edge.
  task automatic cyc(string nm, logic [6:0] exp, logic exp_h);
    logic [6:0] act;
    @(negedge CLK);
    act = bus.stall;
    chk({nm, ".stall"}, {25'd0, act}, {25'd0, exp});
    chk({nm, ".halted"}, {31'd0, bus.halted}, {31'd0, exp_h});
    if (RST) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!exp_h && !exp[6]) m_stall++;
      if (exp[4]) m_flush++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = mk("idle",        1, 0, 0,  0,  0,  0, 0, 0, W_ALL_EN);
    vecs[1]  = mk("lu_rs",       1, 1, 2,  2,  4,  1, 0, 0, W_BUBBLE);
    vecs[2]  = mk("lu_rt",       1, 1, 2,  1,  2,  1, 0, 0, W_BUBBLE);
    vecs[3]  = mk("rt_unused",   1, 1, 2,  1,  2,  0, 0, 0, W_ALL_EN);
    vecs[4]  = mk("zero_reg",    1, 1, 0,  0,  0,  1, 0, 0, W_ALL_EN);
    vecs[5]  = mk("no_load",     1, 0, 2,  2,  2,  1, 0, 0, W_ALL_EN);
    vecs[6]  = mk("fetch_wait",  0, 0, 0,  0,  0,  0, 0, 0, W_BUBBLE);
    vecs[7]  = mk("redir_lu",    1, 1, 2,  2,  0,  0, 1, 0, W_REDIR);
    vecs[8]  = mk("redir_ifw",   0, 0, 0,  0,  0,  0, 1, 0, W_REDIR);
    vecs[9]  = mk("lu_r31",      1, 1, 31, 31, 0,  0, 0, 0, W_BUBBLE);
    vecs[10] = mk("load_hit",    1, 0, 0,  0,  0,  0, 0, 1, W_ALL_EN);
    vecs[11] = mk("lu_miss",     1, 1, 5,  4,  6,  1, 0, 0, W_ALL_EN);

    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    cyc("reset", W_RESET, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      idle();
      bus.ihit = vecs[i].ihit; bus.ex_dMemRead = vecs[i].ex_rd; bus.ex_wsel = vecs[i].wsel;
      bus.id_rs = vecs[i].rs; bus.id_rt = vecs[i].rt; bus.id_uses_rt = vecs[i].uses_rt;
      bus.ex_redirect = vecs[i].redir; bus.mem_dMemRead = vecs[i].mem_rd;
      cyc(vecs[i].nm, vecs[i].exp, 1'b0);
    end

    // Load-use bubble followed by the bubble itself in EX: pipeline resumes.
    idle(); bus.ex_dMemRead = 1; bus.ex_wsel = 2; bus.id_rs = 3; bus.id_rt = 2; bus.id_uses_rt = 1;
    cyc("lu_seq0", W_BUBBLE, 1'b0);
    idle(); bus.id_rs = 3; bus.id_rt = 2; bus.id_uses_rt = 1;
    cyc("lu_seq1", W_ALL_EN, 1'b0);

    // Store waits three cycles, released on dhit with zero latency.
    for (int i = 0; i < 3; i++) begin
      idle(); bus.mem_dMemWrite = 1; bus.dhit = 0;
      cyc("sw_wait", W_FROZEN, 1'b0);
      chk("sw_state", 32'(dut.state_q), 32'(MEM_WAIT));
    end
    idle(); bus.mem_dMemWrite = 1;
    cyc("sw_done", W_ALL_EN, 1'b0);
    chk("sw_state_run", 32'(dut.state_q), 32'(RUN));

    // Redirect arriving during a data wait is held and applied on the dhit cycle only.
    idle(); bus.mem_dMemRead = 1; bus.dhit = 0; bus.ex_redirect = 1;
    cyc("rw0", W_FROZEN, 1'b0);
    idle(); bus.mem_dMemRead = 1; bus.dhit = 0;
    cyc("rw1", W_FROZEN, 1'b0);
    idle(); bus.mem_dMemRead = 1;
    cyc("rw_hit", W_REDIR, 1'b0);
    idle();
    cyc("rw_after", W_ALL_EN, 1'b0);

    // Reset discards MEM_WAIT and a pending redirect.
    idle(); bus.mem_dMemWrite = 1; bus.dhit = 0; bus.ex_redirect = 1;
    cyc("rp0", W_FROZEN, 1'b0);
    idle(); RST = 1'b1;
    cyc("rp_rst", W_RESET, 1'b0);
    RST = 1'b0;
    idle();
    cyc("rp_after", W_ALL_EN, 1'b0);
    chk("rp_state", 32'(dut.state_q), 32'(RUN));

    // Fetch wait cycles feed the stall counter before halting.
    idle(); bus.ihit = 0;
    cyc("pre_halt_ifw", W_BUBBLE, 1'b0);
    idle(); bus.wb_halt = 1;
    cyc("halt_edge", W_ALL_EN, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.ex_redirect = 1; bus.ihit = 0;
      cyc("halted", W_FROZEN, 1'b1);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(m_stall));
    chk("flush_count", flush_count, 32'(m_flush));
`endif
    idle(); RST = 1'b1;
    cyc("halt_rst", W_RESET, 1'b0);
    RST = 1'b0;
    idle();
    cyc("halt_release", W_ALL_EN, 1'b0);

    // Halt during a data wait still wins.
    idle(); bus.mem_dMemWrite = 1; bus.dhit = 0; bus.wb_halt = 1; bus.ex_redirect = 1;
    cyc("mw_halt0", W_FROZEN, 1'b0);
    idle();
    cyc("mw_halt1", W_FROZEN, 1'b1);
    chk("mw_halt_state", 32'(dut.state_q), 32'(HALTED));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles2", stall_cycles, 32'(m_stall));
`endif
    idle(); RST = 1'b1;
    cyc("final_rst", W_RESET, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
